capture_buffer_reader: RTL and testbench

CAPTURE_BUFFER_READER -- requirements
Module: capture_buffer_reader

---
 rtl/capture_buffer_reader_pkg.sv | 10 +
 rtl/capture_buffer_reader_addr_counter.sv | 43 ++++
 rtl/capture_buffer_reader.sv | 150 +++++++++++++++
 tb/tb_capture_buffer_reader.sv | 509 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/capture_buffer_reader_pkg.sv
// Shared constants for the capture buffer and its reader: default geometry
// and I/Q sample widths, so both sides of the read port agree.
package capture_buffer_reader_pkg;

  localparam int CAPTURE_LENGTH     = 32;
  localparam int CAPTURE_INDEX_BITS = 5;
  localparam int CAPTURE_I_BITS     = 8;
  localparam int CAPTURE_Q_BITS     = 8;

endpackage

// File: rtl/capture_buffer_reader_addr_counter.sv
// Read-address counter for the capture buffer reader: synchronous clear,
// saturating increment and a terminal-count flag at the last sample.
module capture_addr_counter
  import capture_buffer_reader_pkg::*;
#(
  parameter int buffer_length = CAPTURE_LENGTH,
  parameter int index_bits    = CAPTURE_INDEX_BITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  inc,
  output logic [index_bits-1:0] count,
  output logic                  tc
);

  localparam logic [index_bits-1:0] LAST = index_bits'(buffer_length - 1);

  logic [index_bits-1:0] count_d, count_q;

  // NOTE: count_d gets its default before any branch, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && (count_q != LAST)) begin
      count_d = count_q + 1'b1;
    end
  end

  // NOTE: non-blocking assignments make every flop sample pre-edge values, independent of block order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign tc    = (count_q == LAST);

endmodule

// File: rtl/capture_buffer_reader.sv
// Drains a capture buffer one sample at a time: a single outstanding read,
// the returned I/Q held on a valid/ready output, and a done pulse after the last sample.
module capture_buffer_reader
  import capture_buffer_reader_pkg::*;
#(
  parameter int buffer_length = CAPTURE_LENGTH,
  parameter int index_bits    = CAPTURE_INDEX_BITS,
  parameter int i_bits        = CAPTURE_I_BITS,
  parameter int q_bits        = CAPTURE_Q_BITS
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     abort,
  output logic [index_bits-1:0]    m_axi_raddr,
  output logic                     m_axi_rvalid,
  output logic                     m_axi_rready,
  input  logic                     s_axi_rvalid,
  input  logic signed [i_bits-1:0] i,
  input  logic signed [q_bits-1:0] q,
  output logic                     o_valid,
  output logic signed [i_bits-1:0] o_i,
  output logic signed [q_bits-1:0] o_q,
  input  logic                     o_ready,
  output logic                     busy,
  output logic                     done
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_REQ  = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_HOLD = 3'd3;
  localparam logic [2:0] ST_FIN  = 3'd4;

  typedef enum logic [2:0] {
    IDLE = ST_IDLE,
    REQ  = ST_REQ,
    WAIT = ST_WAIT,
    HOLD = ST_HOLD,
    FIN  = ST_FIN
  } state_e;

  state_e state_d, state_q;

  logic                     rvalid_d, rvalid_q;
  logic                     rready_d, rready_q;
  logic                     o_valid_d, o_valid_q;
  logic                     busy_d, busy_q;
  logic                     done_d, done_q;
  logic signed [i_bits-1:0] o_i_d, o_i_q;
  logic signed [q_bits-1:0] o_q_d, o_q_q;

  logic                  addr_clear;
  logic                  addr_inc;
  logic                  addr_tc;
  logic [index_bits-1:0] addr;

  capture_addr_counter #(
    .buffer_length (buffer_length),
    .index_bits    (index_bits)
  ) u_addr (
    .clk   (clk),
    .reset (reset),
    .clear (addr_clear),
    .inc   (addr_inc),
    .count (addr),
    .tc    (addr_tc)
  );

  always_comb begin
    state_d    = state_q;
    addr_clear = 1'b0;
    addr_inc   = 1'b0;
    o_i_d      = o_i_q;
    o_q_d      = o_q_q;

    // Abort outranks o_ready and s_axi_rvalid; in IDLE it is meaningless.
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            addr_clear = 1'b1;
            state_d    = REQ;
          end
        end
        REQ:  state_d = WAIT;
        WAIT: begin
          if (s_axi_rvalid) begin
            o_i_d   = i;
            o_q_d   = q;
            state_d = HOLD;
          end
        end
        HOLD: begin
          if (o_ready) begin
            if (addr_tc) begin
              state_d = FIN;
            end else begin
              addr_inc = 1'b1;
              state_d  = REQ;
            end
          end
        end
        FIN:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    // Outputs are decoded from the next state so they come straight off flops.
    rvalid_d  = (state_d == REQ);
    rready_d  = (state_d == REQ) || (state_d == WAIT);
    o_valid_d = (state_d == HOLD);
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == FIN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      rvalid_q  <= 1'b0;
      rready_q  <= 1'b0;
      o_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      o_i_q     <= '0;
      o_q_q     <= '0;
    end else begin
      state_q   <= state_d;
      rvalid_q  <= rvalid_d;
      rready_q  <= rready_d;
      o_valid_q <= o_valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      o_i_q     <= o_i_d;
      o_q_q     <= o_q_d;
    end
  end

  assign m_axi_raddr  = addr;
  assign m_axi_rvalid = rvalid_q;
  assign m_axi_rready = rready_q;
  assign o_valid      = o_valid_q;
  assign o_i          = o_i_q;
  assign o_q          = o_q_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_capture_buffer_reader.sv
// Bench for capture_buffer_reader: a buffer model holding (k, -k) answers each
// read after a programmable latency; a second instance covers buffer_length=1.
module tb_capture_buffer_reader;

  localparam int LEN = 32;

  logic clk;
  logic reset;
  logic start;
  logic abort;
  logic [4:0] m_axi_raddr;
  logic m_axi_rvalid;
  logic m_axi_rready;
  logic s_axi_rvalid;
  logic signed [7:0] i;
  logic signed [7:0] q;
  logic o_valid;
  logic signed [7:0] o_i;
  logic signed [7:0] o_q;
  logic o_ready;
  logic busy;
  logic done;

  logic start1;
  logic [0:0] m_axi_raddr1;
  logic m_axi_rvalid1;
  logic m_axi_rready1;
  logic s_axi_rvalid1;
  logic signed [7:0] i1;
  logic signed [7:0] q1;
  logic o_valid1;
  logic signed [7:0] o_i1;
  logic signed [7:0] o_q1;
  logic o_ready1;
  logic busy1;
  logic done1;

  int errors = 0;
  int checks = 0;
  int lat = 1;
  bit rand_lat = 0;
  int resp_addr;
  int resp_lat;
  int req_addr_q[$];
  int samp_i_q[$];
  int samp_q_q[$];
  int done_count = 0;

  capture_buffer_reader dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .m_axi_raddr  (m_axi_raddr),
    .m_axi_rvalid (m_axi_rvalid),
    .m_axi_rready (m_axi_rready),
    .s_axi_rvalid (s_axi_rvalid),
    .i            (i),
    .q            (q),
    .o_valid      (o_valid),
    .o_i          (o_i),
    .o_q          (o_q),
    .o_ready      (o_ready),
    .busy         (busy),
    .done         (done)
  );

  capture_buffer_reader #(
    .buffer_length (1),
    .index_bits    (1),
    .i_bits        (8),
    .q_bits        (8)
  ) dut1 (
    .clk          (clk),
    .reset        (reset),
    .start        (start1),
    .abort        (1'b0),
    .m_axi_raddr  (m_axi_raddr1),
    .m_axi_rvalid (m_axi_rvalid1),
    .m_axi_rready (m_axi_rready1),
    .s_axi_rvalid (s_axi_rvalid1),
    .i            (i1),
    .q            (q1),
    .o_valid      (o_valid1),
    .o_i          (o_i1),
    .o_q          (o_q1),
    .o_ready      (o_ready1),
    .busy         (busy1),
    .done         (done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Buffer model: word k holds (k, -k); one response pulse per request.
  initial begin : responder
    forever begin
      @(negedge clk);
      if (!reset && m_axi_rvalid) begin
        resp_addr = int'(m_axi_raddr);
        req_addr_q.push_back(resp_addr);
        resp_lat = rand_lat ? int'($urandom_range(1, 4)) : lat;
        repeat (resp_lat) @(negedge clk);
        s_axi_rvalid = 1'b1;
        i = 8'(resp_addr);
        q = 8'(-resp_addr);
        @(negedge clk);
        s_axi_rvalid = 1'b0;
      end
    end
  end

  always begin : monitor
    @(negedge clk);
    #1;
    if (!reset) begin
      if (o_valid && o_ready) begin
        samp_i_q.push_back(int'(o_i));
        samp_q_q.push_back(int'(o_q));
      end
      if (done) done_count++;
    end
  end

  task automatic clear_logs();
    req_addr_q.delete();
    samp_i_q.delete();
    samp_q_q.delete();
    done_count = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!done && cycles < budget);
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({m_axi_rvalid, m_axi_rready, o_valid, busy, done} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 00000", {m_axi_rvalid, m_axi_rready, o_valid, busy, done});
    end
    checks++;
    if (m_axi_raddr !== 5'd0) begin
      errors++;
      $display("FAIL reset_raddr: got %0d want 0", m_axi_raddr);
    end
    checks++;
    if (o_i !== 8'sd0 || o_q !== 8'sd0) begin
      errors++;
      $display("FAIL reset_data: got %0d/%0d want 0/0", o_i, o_q);
    end
    @(negedge clk);
    reset = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || m_axi_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL abort_in_idle: got busy=%b rvalid=%b want 0/0", busy, m_axi_rvalid);
    end
    @(negedge clk);
  endtask

  task automatic test_stream();
    int cyc;
    lat = 1;
    rand_lat = 0;
    o_ready = 1'b1;
    clear_logs();
    pulse_start();
    checks++;
    if (m_axi_rvalid !== 1'b1 || m_axi_raddr !== 5'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL stream_first_req: got rvalid=%b raddr=%0d busy=%b want 1/0/1", m_axi_rvalid, m_axi_raddr, busy);
    end
    wait_done(300, cyc);
    checks++;
    if (cyc != 96 || done !== 1'b1) begin
      errors++;
      $display("FAIL stream_cycles: got %0d (done=%b) want 96", cyc, done);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || done_count != 1) begin
      errors++;
      $display("FAIL stream_done_pulse: got done=%b busy=%b pulses=%0d want 0/0/1", done, busy, done_count);
    end
    checks++;
    if (samp_i_q.size() != LEN || req_addr_q.size() != LEN) begin
      errors++;
      $display("FAIL stream_count: got %0d samples %0d reqs want %0d", samp_i_q.size(), req_addr_q.size(), LEN);
    end
    for (int k = 0; k < samp_i_q.size() && k < LEN; k++) begin
      checks++;
      if (samp_i_q[k] != k || samp_q_q[k] != -k) begin
        errors++;
        $display("FAIL stream_sample[%0d]: got %0d/%0d want %0d/%0d", k, samp_i_q[k], samp_q_q[k], k, -k);
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_backpressure();
    int n;
    int cyc;
    o_ready = 1'b1;
    clear_logs();
    pulse_start();
    n = 0;
    while (!(m_axi_rvalid && m_axi_raddr == 5'd3) && n < 100) begin
      @(negedge clk);
      n++;
    end
    o_ready = 1'b0;
    n = 0;
    while (!o_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (o_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_reach_hold: got o_valid=%b want 1", o_valid);
    end
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (o_valid !== 1'b1 || o_i !== 8'sd3 || o_q !== -8'sd3) begin
        errors++;
        $display("FAIL bp_hold_data[%0d]: got v=%b %0d/%0d want 1 3/-3", c, o_valid, o_i, o_q);
      end
      checks++;
      if (m_axi_rvalid !== 1'b0 || m_axi_rready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold_bus[%0d]: got rvalid=%b rready=%b want 0/0", c, m_axi_rvalid, m_axi_rready);
      end
      @(negedge clk);
    end
    checks++;
    if (req_addr_q.size() != 4) begin
      errors++;
      $display("FAIL bp_no_extra_req: got %0d requests want 4", req_addr_q.size());
    end
    o_ready = 1'b1;
    wait_done(300, cyc);
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL bp_timeout: got done=%b want 1", done);
    end
    @(negedge clk);
    checks++;
    if (samp_i_q.size() != LEN || req_addr_q.size() != LEN) begin
      errors++;
      $display("FAIL bp_count: got %0d samples %0d reqs want %0d", samp_i_q.size(), req_addr_q.size(), LEN);
    end
    for (int k = 0; k < samp_i_q.size() && k < LEN; k++) begin
      checks++;
      if (samp_i_q[k] != k || samp_q_q[k] != -k) begin
        errors++;
        $display("FAIL bp_sample[%0d]: got %0d/%0d want %0d/%0d", k, samp_i_q[k], samp_q_q[k], k, -k);
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_random_latency();
    int cyc;
    rand_lat = 1;
    o_ready = 1'b1;
    clear_logs();
    pulse_start();
    wait_done(800, cyc);
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL rl_timeout: got done=%b want 1", done);
    end
    @(negedge clk);
    rand_lat = 0;
    checks++;
    if (samp_i_q.size() != LEN || req_addr_q.size() != LEN) begin
      errors++;
      $display("FAIL rl_count: got %0d samples %0d reqs want %0d", samp_i_q.size(), req_addr_q.size(), LEN);
    end
    for (int k = 0; k < samp_i_q.size() && k < LEN; k++) begin
      checks++;
      if (samp_i_q[k] != k || samp_q_q[k] != -k || req_addr_q[k] != k) begin
        errors++;
        $display("FAIL rl_sample[%0d]: got %0d/%0d addr %0d want %0d/%0d addr %0d", k, samp_i_q[k], samp_q_q[k], req_addr_q[k], k, -k, k);
      end
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_abort();
    int n;
    int cyc;
    lat = 2;
    o_ready = 1'b1;
    clear_logs();
    pulse_start();
    n = 0;
    while (!(m_axi_rvalid && m_axi_raddr == 5'd10) && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checks++;
    if (m_axi_rvalid !== 1'b0 || m_axi_rready !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_wait_state: got rvalid=%b rready=%b busy=%b want 0/1/1", m_axi_rvalid, m_axi_rready, busy);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || o_valid !== 1'b0 || m_axi_rready !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: got busy=%b o_valid=%b rready=%b want 0/0/0", busy, o_valid, m_axi_rready);
    end
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_late_resp: got o_valid=%b busy=%b want 0/0", o_valid, busy);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (done_count != 0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d pulses want 0", done_count);
    end
    clear_logs();
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    checks++;
    if (busy !== 1'b1 || m_axi_rvalid !== 1'b1 || m_axi_raddr !== 5'd0) begin
      errors++;
      $display("FAIL abort_restart: got busy=%b rvalid=%b raddr=%0d want 1/1/0", busy, m_axi_rvalid, m_axi_raddr);
    end
    wait_done(500, cyc);
    @(negedge clk);
    checks++;
    if (samp_i_q.size() != LEN || done_count != 1) begin
      errors++;
      $display("FAIL abort_rerun: got %0d samples %0d pulses want %0d/1", samp_i_q.size(), done_count, LEN);
    end else begin
      checks++;
      if (samp_i_q[0] != 0 || samp_q_q[LEN-1] != -(LEN-1)) begin
        errors++;
        $display("FAIL abort_rerun_data: got first=%0d last_q=%0d want 0/%0d", samp_i_q[0], samp_q_q[LEN-1], -(LEN-1));
      end
    end
    lat = 1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid_drain();
    int n;
    int cyc;
    lat = 1;
    o_ready = 1'b1;
    clear_logs();
    pulse_start();
    n = 0;
    while (!(m_axi_rvalid && m_axi_raddr == 5'd5) && n < 100) begin
      @(negedge clk);
      n++;
    end
    pulse_start();
    n = 0;
    while (!(o_valid && o_i == 8'sd8) && n < 100) begin
      @(negedge clk);
      n++;
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({m_axi_rvalid, m_axi_rready, o_valid, busy, done} !== 5'b0 || m_axi_raddr !== 5'd0) begin
      errors++;
      $display("FAIL async_reset_flags: got %b raddr=%0d want 00000/0", {m_axi_rvalid, m_axi_rready, o_valid, busy, done}, m_axi_raddr);
    end
    checks++;
    if (o_i !== 8'sd0 || o_q !== 8'sd0) begin
      errors++;
      $display("FAIL async_reset_data: got %0d/%0d want 0/0", o_i, o_q);
    end
    checks++;
    if (req_addr_q.size() != 9) begin
      errors++;
      $display("FAIL busy_start_ignored_count: got %0d requests want 9", req_addr_q.size());
    end
    for (int k = 0; k < req_addr_q.size() && k < 9; k++) begin
      checks++;
      if (req_addr_q[k] != k) begin
        errors++;
        $display("FAIL busy_start_ignored[%0d]: got addr %0d want %0d", k, req_addr_q[k], k);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    clear_logs();
    pulse_start();
    checks++;
    if (m_axi_rvalid !== 1'b1 || m_axi_raddr !== 5'd0) begin
      errors++;
      $display("FAIL post_reset_start: got rvalid=%b raddr=%0d want 1/0", m_axi_rvalid, m_axi_raddr);
    end
    wait_done(300, cyc);
    @(negedge clk);
    checks++;
    if (samp_i_q.size() != LEN || done_count != 1) begin
      errors++;
      $display("FAIL post_reset_run: got %0d samples %0d pulses want %0d/1", samp_i_q.size(), done_count, LEN);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_single();
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    checks++;
    if (m_axi_rvalid1 !== 1'b1 || m_axi_raddr1 !== 1'b0 || busy1 !== 1'b1) begin
      errors++;
      $display("FAIL single_req: got rvalid=%b raddr=%0d busy=%b want 1/0/1", m_axi_rvalid1, m_axi_raddr1, busy1);
    end
    s_axi_rvalid1 = 1'b1;
    i1 = 8'sd99;
    q1 = 8'sd99;
    @(negedge clk);
    checks++;
    if (m_axi_rvalid1 !== 1'b0 || m_axi_rready1 !== 1'b1 || o_valid1 !== 1'b0) begin
      errors++;
      $display("FAIL single_wait: got rvalid=%b rready=%b o_valid=%b want 0/1/0", m_axi_rvalid1, m_axi_rready1, o_valid1);
    end
    i1 = 8'sd7;
    q1 = -8'sd7;
    @(negedge clk);
    s_axi_rvalid1 = 1'b0;
    checks++;
    if (o_valid1 !== 1'b1 || o_i1 !== 8'sd7 || o_q1 !== -8'sd7) begin
      errors++;
      $display("FAIL single_sample: got v=%b %0d/%0d want 1 7/-7", o_valid1, o_i1, o_q1);
    end
    o_ready1 = 1'b1;
    @(negedge clk);
    o_ready1 = 1'b0;
    checks++;
    if (done1 !== 1'b1 || o_valid1 !== 1'b0 || m_axi_rvalid1 !== 1'b0) begin
      errors++;
      $display("FAIL single_fin: got done=%b o_valid=%b rvalid=%b want 1/0/0", done1, o_valid1, m_axi_rvalid1);
    end
    @(negedge clk);
    checks++;
    if (done1 !== 1'b0 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL single_idle: got done=%b busy=%b want 0/0", done1, busy1);
    end
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    o_ready = 1'b0;
    s_axi_rvalid = 1'b0;
    i = '0;
    q = '0;
    start1 = 1'b0;
    s_axi_rvalid1 = 1'b0;
    i1 = '0;
    q1 = '0;
    o_ready1 = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_random_latency();
    test_abort();
    test_reset_mid_drain();
    test_single();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no completion want finish before 500000");
    $fatal(1, "watchdog expired");
  end

endmodule
